// File: rtl/frame_capture_if.sv
// frame_capture_if: byte stream from frame_capture to the C1 decoder.
// valid/ready handshake carrying a data byte, its frame index and a last flag.
interface frame_capture_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data;
   logic [4:0]       idx;
   logic             valid;
   logic             ready;
   logic             last;

   modport master (output data, idx, valid, last, input ready);
   modport slave  (input data, idx, valid, last, output ready);
endinterface

// File: rtl/frame_capture.sv
// frame_capture: frame-syncs the symbol window, snapshots complete frames
// and streams them out. Optional FRAME_STATS_EN adds the ERR_CNT counter.
module frame_capture #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 33,
   parameter int CNT_W = 16
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [DEPTH-1:0][WIDTH-1:0]  WIN,
   input  logic                         SYM_STB,
   input  logic                         SYNC_STB,
   output logic [WIDTH-1:0]             SUB,
   output logic                         SUB_VALID,
   frame_capture_if.master              c1,
   output logic                         FRAME_OK,
   output logic                         OVERRUN
`ifdef FRAME_STATS_EN
   ,
   output logic [CNT_W-1:0]             ERR_CNT
`endif
);

   typedef enum logic {HUNT, COUNT} state_t;

   localparam logic [5:0] FULL = 6'(DEPTH);
   localparam logic [5:0] PRE  = 6'(DEPTH - 1);
   localparam logic [4:0] LAST = 5'(DEPTH - 2);

   state_t state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic ok_d, pend_d;
   logic cap_pend, cap_smp;

   logic [DEPTH-1:0][WIDTH-1:0] hold;
   logic [4:0] idx_q;
   logic valid_q;
   logic accept, drain, free, ovr_ev;

   // sync tracking: symbol count and frame-length verdict
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ok_d    = FRAME_OK;
      pend_d  = 1'b0;
      unique case (state_q)
         HUNT: begin
            if (SYNC_STB) begin
               state_d = COUNT;
               cnt_d   = SYM_STB ? 6'd1 : 6'd0;
            end
         end
         COUNT: begin
            if (SYNC_STB) begin
               if (cnt_q == FULL)
                  ok_d = 1'b1;
               else if (cnt_q != 6'd0)
                  ok_d = 1'b0;
               cnt_d = SYM_STB ? 6'd1 : 6'd0;
            end else if (SYM_STB) begin
               if (cnt_q == FULL) begin
                  state_d = HUNT;
                  ok_d    = 1'b0;
                  cnt_d   = 6'd0;
               end else begin
                  cnt_d  = cnt_q + 6'd1;
                  pend_d = (cnt_q == PRE);
               end
            end
         end
         default: ;
      endcase
   end

   // sync state register; cap_smp delays the capture so WIN has settled
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= HUNT;
         cnt_q    <= 6'd0;
         FRAME_OK <= 1'b0;
         cap_pend <= 1'b0;
         cap_smp  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         FRAME_OK <= ok_d;
         cap_pend <= pend_d;
         cap_smp  <= cap_pend;
      end
   end

   assign accept = valid_q & c1.ready;
   assign drain  = accept & (idx_q == LAST);
   assign free   = ~valid_q | drain;
   assign ovr_ev = cap_smp & ~free;

   // hold buffer capture and output stream sequencing
   always_ff @(posedge CLK) begin
      if (RST) begin
         hold      <= '0;
         SUB       <= '0;
         SUB_VALID <= 1'b0;
         OVERRUN   <= 1'b0;
         valid_q   <= 1'b0;
         idx_q     <= 5'd0;
      end else begin
         SUB_VALID <= 1'b0;
         OVERRUN   <= ovr_ev;
         if (accept) begin
            if (idx_q == LAST) begin
               valid_q <= 1'b0;
               idx_q   <= 5'd0;
            end else begin
               idx_q <= idx_q + 5'd1;
            end
         end
         if (cap_smp && free) begin
            hold      <= WIN;
            SUB       <= WIN[0];
            SUB_VALID <= 1'b1;
            valid_q   <= 1'b1;
            idx_q     <= 5'd0;
         end
      end
   end

   assign c1.valid = valid_q;
   assign c1.idx   = idx_q;
   assign c1.data  = hold[6'(idx_q) + 6'd1];
   assign c1.last  = valid_q & (idx_q == LAST);

`ifdef FRAME_STATS_EN
   logic err_ev;

   assign err_ev = ovr_ev | ((state_q == COUNT) &
      ((SYNC_STB & (cnt_q != 6'd0) & (cnt_q != FULL)) |
       (~SYNC_STB & SYM_STB & (cnt_q == FULL))));

   // saturating count of short frames, sync losses and overruns
   always_ff @(posedge CLK) begin
      if (RST)
         ERR_CNT <= '0;
      else if (err_ev && (ERR_CNT != '1))
         ERR_CNT <= ERR_CNT + 1'b1;
   end
`endif

endmodule
